// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the MIPS MEM stage and the debug memory-dump engine.
// The pipeline always owns the RAM port when it asks; the dump engine reads only in free cycles.
module data_mem_arbiter #(
  parameter int unsigned RAM_WIDTH = 16,
  parameter int unsigned RAM_DEPTH = 1024,
  // Same width the RAM derives from clogb2(RAM_DEPTH-1).
  localparam int unsigned ADDR_W = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_re,
  input  logic                 pipe_we,
  input  logic [ADDR_W-1:0]    pipe_addr,
  input  logic [RAM_WIDTH-1:0] pipe_wdata,
  output logic [RAM_WIDTH-1:0] pipe_rdata,
  input  logic                 dump_start,
  input  logic                 dump_abort,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [RAM_WIDTH-1:0] dump_data,
  output logic [ADDR_W-1:0]    dump_addr,
  output logic                 dump_busy,
  output logic                 dump_done,
  output logic [15:0]          stall_cnt,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [RAM_WIDTH-1:0] ram_din,
  output logic                 ram_we,
  input  logic [RAM_WIDTH-1:0] ram_dout
);

  localparam int unsigned     STALL_W   = 16;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 dump_valid_q, dump_valid_d;
  logic [RAM_WIDTH-1:0] dump_data_q, dump_data_d;
  logic [ADDR_W-1:0]    dump_addr_q, dump_addr_d;
  logic                 dump_busy_q, dump_busy_d;
  logic                 dump_done_q, dump_done_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                 pipe_req;

  assign pipe_req   = pipe_re | pipe_we;
  assign pipe_rdata = ram_dout;

  // RAM port mux: the pipeline wins; otherwise the dump address is read.
  always_comb begin
    ram_addr = dump_addr_q;
    ram_din  = pipe_wdata;
    ram_we   = 1'b0;
    if (pipe_req) begin
      ram_addr = pipe_addr;
      ram_we   = pipe_we;
    end
  end

  always_comb begin
    state_d      = state_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    dump_addr_d  = dump_addr_q;
    stall_cnt_d  = stall_cnt_q;

    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d     = READ;
          dump_addr_d = '0;
          stall_cnt_d = '0;
        end
      end
      READ: begin
        if (pipe_req) begin
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end else begin
          dump_data_d  = ram_dout;
          dump_valid_d = 1'b1;
          state_d      = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (dump_valid_q && dump_ready) begin
          dump_valid_d = 1'b0;
          if (dump_addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            dump_addr_d = dump_addr_q + ADDR_W'(1);
            state_d     = READ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the state wanted this cycle.
    if (dump_abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      dump_valid_d = 1'b0;
      dump_data_d  = dump_data_q;
      dump_addr_d  = dump_addr_q;
      stall_cnt_d  = stall_cnt_q;
    end

    dump_busy_d = (state_d != IDLE);
    dump_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      dump_addr_q  <= '0;
      dump_busy_q  <= 1'b0;
      dump_done_q  <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_addr_q  <= dump_addr_d;
      dump_busy_q  <= dump_busy_d;
      dump_done_q  <= dump_done_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign dump_addr  = dump_addr_q;
  assign dump_busy  = dump_busy_q;
  assign dump_done  = dump_done_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
